lif_neuron_accum: RTL

- Downstream consumer of the synapse stage's 16-bit weight word (8.8 unsigned fixed point: integer byte [15:8], fractional byte [7:0]).
- Integrates weighted synaptic events into a membrane potential. On each time-step tick it applies leak, compares against threshold, and emits a spike address event toward the router.
- Also handles the refractory period and valid/ready backpressure in both directions.

---
 rtl/lif_neuron_accum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_accum.sv
// Leaky integrate-and-fire neuron: accumulates 8.8 synaptic weights into a 12.8 membrane,
// leaks/thresholds on each tick and emits a spike address event. Define SPIKE_COUNT_EN for spike_count.
module lif_neuron_accum #(
    parameter int unsigned          V_WIDTH      = 20,
    parameter logic [V_WIDTH-1:0]   V_TH         = 20'h00A00,
    parameter logic [V_WIDTH-1:0]   V_RESET      = 20'h00000,
    parameter int unsigned          LEAK_SHIFT   = 3,
    parameter int unsigned          REFRAC_STEPS = 2,
    parameter logic [6:0]           NEURON_ID    = 7'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kill,
    input  logic [15:0]        syn_weight,
    input  logic               syn_inh,
    input  logic               syn_valid,
    output logic               syn_ready,
    input  logic               tick,
    output logic               spike_valid,
    input  logic               spike_ready,
    output logic [6:0]         spike_addr,
    output logic [V_WIDTH-1:0] v_mem,
    output logic               tick_ovf
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]        spike_count
`endif
);

    localparam int unsigned SUM_W = V_WIDTH + 1;
    localparam int unsigned CNT_W = (REFRAC_STEPS < 2) ? 1 : $clog2(REFRAC_STEPS + 1);

    typedef enum logic [2:0] {
        S_INTEG,
        S_LEAK,
        S_CHECK,
        S_FIRE,
        S_REFRAC
    } state_t;

    state_t             state_q;
    logic [V_WIDTH-1:0] v_mem_q;
    logic               syn_ready_q;
    logic               spike_valid_q;
    logic [6:0]         spike_addr_q;
    logic               tick_ovf_q;
    logic               tick_pending_q;
    logic [CNT_W-1:0]   refrac_cnt_q;

    logic [SUM_W-1:0]   v_sum_c;
    logic [V_WIDTH-1:0] w_ext_c;
    logic [V_WIDTH-1:0] v_exc_d;
    logic [V_WIDTH-1:0] v_inh_d;
    logic [V_WIDTH-1:0] v_syn_d;
    logic [V_WIDTH-1:0] v_leak_d;
    logic               tick_defer_c;
    logic               spike_hs_c;

    // Membrane arithmetic: saturating add, floored subtract, shift leak.
    always_comb begin
        w_ext_c  = V_WIDTH'(syn_weight);
        v_sum_c  = SUM_W'(v_mem_q) + SUM_W'(syn_weight);
        v_exc_d  = v_sum_c[V_WIDTH] ? '1 : v_sum_c[V_WIDTH-1:0];
        v_inh_d  = (w_ext_c > v_mem_q) ? '0 : (v_mem_q - w_ext_c);
        v_syn_d  = syn_inh ? v_inh_d : v_exc_d;
        v_leak_d = (LEAK_SHIFT == 0) ? v_mem_q : (v_mem_q - (v_mem_q >> LEAK_SHIFT));
    end

    // Ticks landing in the busy states are deferred; a second one is lost.
    assign tick_defer_c = tick && ((state_q == S_LEAK) || (state_q == S_CHECK) || (state_q == S_FIRE));
    assign spike_hs_c   = (state_q == S_FIRE) && spike_valid_q && spike_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_INTEG;
            v_mem_q        <= V_RESET;
            syn_ready_q    <= 1'b0;
            spike_valid_q  <= 1'b0;
            spike_addr_q   <= '0;
            tick_ovf_q     <= 1'b0;
            tick_pending_q <= 1'b0;
            refrac_cnt_q   <= '0;
        end else if (kill) begin
            state_q        <= S_INTEG;
            v_mem_q        <= V_RESET;
            syn_ready_q    <= 1'b1;
            spike_valid_q  <= 1'b0;
            spike_addr_q   <= '0;
            tick_ovf_q     <= 1'b0;
            tick_pending_q <= 1'b0;
            refrac_cnt_q   <= '0;
        end else begin
            if (tick_defer_c) begin
                if (tick_pending_q) begin
                    tick_ovf_q <= 1'b1;
                end else begin
                    tick_pending_q <= 1'b1;
                end
            end

            case (state_q)
                S_INTEG: begin
                    syn_ready_q <= 1'b1;
                    if (syn_valid && syn_ready_q) begin
                        v_mem_q <= v_syn_d;
                    end
                    // A fresh tick colliding with the pending one stays pending.
                    if (tick || tick_pending_q) begin
                        state_q        <= S_LEAK;
                        syn_ready_q    <= 1'b0;
                        tick_pending_q <= tick_pending_q && tick;
                    end
                end
                S_LEAK: begin
                    v_mem_q <= v_leak_d;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (v_mem_q >= V_TH) begin
                        state_q       <= S_FIRE;
                        spike_valid_q <= 1'b1;
                        spike_addr_q  <= NEURON_ID;
                    end else begin
                        state_q     <= S_INTEG;
                        syn_ready_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (spike_hs_c) begin
                        spike_valid_q <= 1'b0;
                        spike_addr_q  <= '0;
                        v_mem_q       <= V_RESET;
                        syn_ready_q   <= 1'b1;
                        if (REFRAC_STEPS == 0) begin
                            state_q <= S_INTEG;
                        end else begin
                            state_q      <= S_REFRAC;
                            refrac_cnt_q <= CNT_W'(REFRAC_STEPS);
                        end
                    end
                end
                S_REFRAC: begin
                    // Weights are acknowledged but discarded while refractory.
                    syn_ready_q <= 1'b1;
                    if (tick) begin
                        refrac_cnt_q <= refrac_cnt_q - CNT_W'(1);
                        if (refrac_cnt_q <= CNT_W'(1)) begin
                            state_q <= S_INTEG;
                        end
                    end
                end
                default: begin
                    state_q <= S_INTEG;
                end
            endcase
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_count_q;

    // Saturating count of completed spike handshakes.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            spike_count_q <= '0;
        end else if (spike_hs_c && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`endif

    assign syn_ready   = syn_ready_q;
    assign spike_valid = spike_valid_q;
    assign spike_addr  = spike_addr_q;
    assign v_mem       = v_mem_q;
    assign tick_ovf    = tick_ovf_q;

endmodule
